// File: rtl/con_ff_unit.sv
// rtl/con_ff_unit.sv - branch-condition unit with registered CON flag and debug counters
//
// Purpose: decodes the condition field of the instruction register, tests the bus
// value (zero / sign), and latches the result into the CON flag that the control
// unit consumes for conditional branches. An optional input stage (PIPE=1) delays
// the evaluation by one edge. Saturating counters track evaluations and taken results.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   clr_n      in   asynchronous active-low reset
//   con_in     in   capture strobe: evaluate condition this cycle
//   con_clr    in   synchronous clear of con_out and con_valid
//   ir_in      in   instruction register (condition field at COND_LSB)
//   bus_in     in   value under test
//   con_out    out  registered CON flag (1 = branch taken)
//   con_valid  out  con_out holds a result not yet cleared
//   busy       out  PIPE=1: capture held in the input stage; 0 when PIPE=0
//   eval_cnt   out  completed evaluations, saturating
//   taken_cnt  out  completed evaluations with result 1, saturating

module con_ff_unit #(
  parameter int DATA_W   = 32,
  parameter int COND_LSB = 19,
  parameter int COND_W   = 2,
  parameter int PIPE     = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              con_in,
  input  logic              con_clr,
  input  logic [31:0]       ir_in,
  input  logic [DATA_W-1:0] bus_in,
  output logic              con_out,
  output logic              con_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  eval_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  generate
    if (COND_W != 2 && COND_W != 3) begin : g_bad_cond_w
      $error("con_ff_unit: COND_W must be 2 or 3");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  // Condition decode; a 2-bit field is zero-extended so codes 00-11 keep their meaning.
  function automatic logic f_eval(input logic [2:0] code, input logic [DATA_W-1:0] bus);
    logic z;
    logic n;
    logic res;
    z = (bus == '0);
    n = bus[DATA_W-1];
    case (code)
      3'b000:  res = z;
      3'b001:  res = ~z;
      3'b010:  res = ~n;
      3'b011:  res = n;
      3'b100:  res = ~n & ~z;
      3'b101:  res = n | z;
      3'b110:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [2:0] w_code;
  logic       w_done;
  logic       w_res;
  logic       w_unused_ir;

  always_comb begin
    w_code = '0;
    w_code[COND_W-1:0] = ir_in[COND_LSB +: COND_W];
  end

  // Only the condition field of ir_in is consumed.
  assign w_unused_ir = ^ir_in;

  generate
    if (PIPE != 0) begin : g_pipe
      logic              r_stg_valid;
      logic [2:0]        r_stg_code;
      logic [DATA_W-1:0] r_stg_bus;

      // The stage holds a private copy of code and bus so later bus changes cannot
      // disturb an in-flight evaluation. con_clr deliberately does not cancel it.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          r_stg_valid <= 1'b0;
          r_stg_code  <= '0;
          r_stg_bus   <= '0;
        end else begin
          r_stg_valid <= con_in;
          if (con_in) begin
            r_stg_code <= w_code;
            r_stg_bus  <= bus_in;
          end
        end
      end

      assign w_done = r_stg_valid;
      assign w_res  = f_eval(r_stg_code, r_stg_bus);
      assign busy   = r_stg_valid;
    end else begin : g_direct
      assign w_done = con_in;
      assign w_res  = f_eval(w_code, bus_in);
      assign busy   = 1'b0;
    end
  endgenerate

  logic             r_con;
  logic             r_valid;
  logic [CNT_W-1:0] r_eval_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // con_clr outranks a completion; a discarded completion is not counted.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_con       <= 1'b0;
      r_valid     <= 1'b0;
      r_eval_cnt  <= '0;
      r_taken_cnt <= '0;
    end else if (con_clr) begin
      r_con   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_done) begin
      r_con   <= w_res;
      r_valid <= 1'b1;
      if (r_eval_cnt != LP_CNT_MAX) begin
        r_eval_cnt <= r_eval_cnt + LP_CNT_ONE;
      end
      if (w_res && (r_taken_cnt != LP_CNT_MAX)) begin
        r_taken_cnt <= r_taken_cnt + LP_CNT_ONE;
      end
    end
  end

  assign con_out   = r_con;
  assign con_valid = r_valid;
  assign eval_cnt  = r_eval_cnt;
  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_con_ff_unit.sv
// tb/tb_con_ff_unit.sv - randomized self-checking bench for con_ff_unit

module tb_con_ff_unit;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        con_in = 1'b0;
  logic        con_clr = 1'b0;
  logic [31:0] ir_in = '0;
  logic [31:0] bus_in = '0;

  logic        co0, cv0, bz0, co1, cv1, bz1, co2, cv2, bz2;
  logic [15:0] ec0, tc0, ec1, tc1;
  logic [1:0]  ec2, tc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  con_ff_unit #(.DATA_W(32), .COND_LSB(19), .COND_W(3), .PIPE(0), .CNT_W(16)) u_p0 (
    .clk(clk), .clr_n(clr_n), .con_in(con_in), .con_clr(con_clr), .ir_in(ir_in),
    .bus_in(bus_in), .con_out(co0), .con_valid(cv0), .busy(bz0),
    .eval_cnt(ec0), .taken_cnt(tc0));

  con_ff_unit #(.DATA_W(32), .COND_LSB(19), .COND_W(3), .PIPE(1), .CNT_W(16)) u_p1 (
    .clk(clk), .clr_n(clr_n), .con_in(con_in), .con_clr(con_clr), .ir_in(ir_in),
    .bus_in(bus_in), .con_out(co1), .con_valid(cv1), .busy(bz1),
    .eval_cnt(ec1), .taken_cnt(tc1));

  con_ff_unit #(.DATA_W(32), .COND_LSB(19), .COND_W(2), .PIPE(1), .CNT_W(2)) u_sat (
    .clk(clk), .clr_n(clr_n), .con_in(con_in), .con_clr(con_clr), .ir_in(ir_in),
    .bus_in(bus_in), .con_out(co2), .con_valid(cv2), .busy(bz2),
    .eval_cnt(ec2), .taken_cnt(tc2));

  // Reference model: one entry per instance.
  int          m_pipe[3]  = '{0, 1, 1};
  int          m_cw[3]    = '{3, 3, 2};
  int          m_max[3]   = '{65535, 65535, 3};
  bit          m_out[3];
  bit          m_valid[3];
  int          m_eval[3];
  int          m_taken[3];
  int          pend_code[3][$];
  logic [31:0] pend_bus[3][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cond(input int code, input logic [31:0] bus);
    bit z = (bus == 0);
    bit n = ($signed(bus) < 0);
    case (code)
      0: return z;
      1: return !z;
      2: return !n;
      3: return n;
      4: return !n && !z;
      5: return n || z;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic reset_models();
    for (int k = 0; k < 3; k++) begin
      m_out[k] = 0; m_valid[k] = 0; m_eval[k] = 0; m_taken[k] = 0;
      pend_code[k].delete(); pend_bus[k].delete();
    end
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int          code;
      int          dcode;
      logic [31:0] dbus;
      bit          done;
      code = int'((ir_in >> 19) & ((32'd1 << m_cw[k]) - 1));
      done = 0; dcode = 0; dbus = '0;
      if (m_pipe[k] == 0) begin
        done = con_in; dcode = code; dbus = bus_in;
      end else begin
        if (pend_code[k].size() > 0) begin
          done = 1; dcode = pend_code[k].pop_front(); dbus = pend_bus[k].pop_front();
        end
        if (con_in) begin
          pend_code[k].push_back(code); pend_bus[k].push_back(bus_in);
        end
      end
      if (con_clr) begin
        m_out[k] = 0; m_valid[k] = 0;
      end else if (done) begin
        m_out[k] = ref_cond(dcode, dbus);
        m_valid[k] = 1;
        if (m_eval[k] < m_max[k]) m_eval[k]++;
        if (m_out[k] && m_taken[k] < m_max[k]) m_taken[k]++;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic co, input logic cv, input logic bz,
                            input logic [31:0] ec, input logic [31:0] tc);
    chk($sformatf("u%0d.con_out", k), {31'd0, co}, {31'd0, m_out[k]});
    chk($sformatf("u%0d.con_valid", k), {31'd0, cv}, {31'd0, m_valid[k]});
    chk($sformatf("u%0d.busy", k), {31'd0, bz}, (pend_code[k].size() > 0) ? 32'd1 : 32'd0);
    chk($sformatf("u%0d.eval_cnt", k), ec, m_eval[k]);
    chk($sformatf("u%0d.taken_cnt", k), tc, m_taken[k]);
  endtask

  task automatic check_all();
    check_inst(0, co0, cv0, bz0, {16'd0, ec0}, {16'd0, tc0});
    check_inst(1, co1, cv1, bz1, {16'd0, ec1}, {16'd0, tc1});
    check_inst(2, co2, cv2, bz2, {30'd0, ec2}, {30'd0, tc2});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!clr_n) reset_models();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit ci, input bit cc, input int code, input logic [31:0] bus);
    con_in = ci; con_clr = cc; ir_in = 32'(code) << 19; bus_in = bus;
  endtask

  task automatic async_reset();
    clr_n = 1'b0;
    #1;
    reset_models();
    check_all();
    drive(0, 0, 0, 0);
    tick();
    clr_n = 1'b1;
  endtask

  initial begin
    reset_models();
    @(negedge clk);
    check_all();
    @(negedge clk);
    clr_n = 1'b1;

    // Zero test on a zero bus, then sign tests on a negative bus.
    drive(1, 0, 0, 32'h0);          tick();
    chk("t1_con_out", {31'd0, co0}, 32'd1);
    chk("t1_eval", {16'd0, ec0}, 32'd1);
    drive(1, 0, 3, 32'h8000_0000);  tick();
    chk("t2_n_out", {31'd0, co0}, 32'd1);
    drive(1, 0, 2, 32'h8000_0000);  tick();
    chk("t2_notn_out", {31'd0, co0}, 32'd0);
    chk("t2_taken", {16'd0, tc0}, 32'd2);

    // Extended codes on the 3-bit instances.
    drive(1, 0, 4, 0); tick();
    drive(1, 0, 5, 0); tick();
    drive(1, 0, 6, 0); tick();
    drive(1, 0, 7, 0); tick();
    chk("t3_code111", {31'd0, co0}, 32'd0);
    drive(0, 0, 7, 0); tick();

    // Back-to-back pipelined captures; bus changes right after each capture.
    async_reset();
    drive(1, 0, 0, 0); tick();
    chk("t4_busy", {31'd0, bz1}, 32'd1);
    drive(1, 0, 0, 5); tick();
    chk("t4_first", {31'd0, co1}, 32'd1);
    drive(1, 0, 0, 0); tick();
    chk("t4_second", {31'd0, co1}, 32'd0);
    drive(0, 0, 0, 9); tick();
    chk("t4_third", {31'd0, co1}, 32'd1);
    drive(0, 0, 0, 9); tick();
    chk("t4_idle", {31'd0, bz1}, 32'd0);

    // Clear coinciding with a completion.
    drive(1, 1, 0, 0); tick();
    chk("t5_clr_valid", {31'd0, cv0}, 32'd0);
    chk("t5_clr_eval", {16'd0, ec0}, 32'd3);

    // Saturation, then reset while a capture sits in the input stage.
    async_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0); tick();
    end
    chk("t6_sat_eval", {30'd0, ec2}, 32'd3);
    chk("t6_sat_taken", {30'd0, tc2}, 32'd3);
    async_reset();
    drive(0, 0, 0, 0); tick();
    chk("t6_no_valid", {31'd0, cv1}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'h8000_0000;
        2: b = $urandom;
        default: b = 32'($urandom_range(1, 10));
      endcase
      ir_in = $urandom;
      bus_in = b;
      con_in = ($urandom_range(0, 1) == 1);
      con_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) begin
        tick();
        async_reset();
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
